// File: rtl/car_game_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : car_game_pkg
//  Purpose  : Shared game-state encoding, default lane geometry, PS/2 scan
//             codes and the lane-to-pixel helper for the car game.
//  Revision : 1.0  initial release
// ============================================================================
package car_game_pkg;

  // Game-state encoding, shared with the drawing and obstacle logic
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAYING   = 2'd1,
    ST_MOVING    = 2'd2,
    ST_GAME_OVER = 2'd3
  } game_state_t;

  // Default lane geometry
  localparam int DEF_NUM_LANES  = 3;
  localparam int DEF_LANE0_X    = 20;
  localparam int DEF_LANE_WIDTH = 40;
  localparam int DEF_STEP_PX    = 4;
  localparam int DEF_XW         = 9;
  localparam int DEF_SCORE_W    = 16;

  // PS/2 set-2 scan codes used by the keyboard decoder
  localparam logic [7:0] SC_ENTER    = 8'h5A;
  localparam logic [7:0] SC_LEFT     = 8'h6B;
  localparam logic [7:0] SC_RIGHT    = 8'h74;
  localparam logic [7:0] SC_EXTENDED = 8'hE0;
  localparam logic [7:0] SC_BREAK    = 8'hF0;

  // Pixel x of the car origin in a given lane
  function automatic int lane_x_px(input int lane0_x, input int lane_width,
                                   input int lane_idx);
    return lane0_x + lane_idx * lane_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/car_lane_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : car_lane_ctrl_if
//  Purpose  : Key levels, frame/collision inputs and car status outputs of
//             the lane controller, grouped as one bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface car_lane_ctrl_if
  import car_game_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int XW        = DEF_XW,
  parameter int SCORE_W   = DEF_SCORE_W
) ();

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic               enter_en;
  logic               left_en;
  logic               right_en;
  logic               frame_tick;
  logic               collision;
  logic [XW-1:0]      car_x;
  logic [LANE_W-1:0]  lane;
  logic               game_active;
  logic               game_over;
  logic               moving;
  logic [SCORE_W-1:0] score;

  // Upstream side: keyboard decoder, frame timing and obstacle logic
  modport master (
    output enter_en, left_en, right_en, frame_tick, collision,
    input  car_x, lane, game_active, game_over, moving, score
  );

  // Lane controller side
  modport slave (
    input  enter_en, left_en, right_en, frame_tick, collision,
    output car_x, lane, game_active, game_over, moving, score
  );

endinterface
`default_nettype wire

// File: rtl/key_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module   : key_edge_detect
//  Purpose  : Registered rising-edge detector for key-held levels. A pulse
//             appears one cycle after a level rises; held levels never repeat.
//  Revision : 1.0  initial release
// ============================================================================
module key_edge_detect #(
  parameter int WIDTH = 3
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [WIDTH-1:0] level,
  output logic      [WIDTH-1:0] pulse
);

  logic [WIDTH-1:0] r_prev;

  // Remember last level and register the rise as a one-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
      pulse  <= '0;
    end else begin
      r_prev <= level;
      pulse  <= level & ~r_prev;
    end
  end

endmodule
`default_nettype wire

// File: rtl/car_lane_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : car_lane_ctrl
//  Purpose  : Game-state FSM and lane-change animation for the player car.
//             Converts key levels into press events, moves the car between
//             lanes per frame tick, keeps a saturating survival score.
//  Revision : 1.0  initial release
// ============================================================================
module car_lane_ctrl
  import car_game_pkg::*;
#(
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter int LANE0_X    = DEF_LANE0_X,
  parameter int LANE_WIDTH = DEF_LANE_WIDTH,
  parameter int STEP_PX    = DEF_STEP_PX,
  parameter int XW         = DEF_XW,
  parameter int SCORE_W    = DEF_SCORE_W
) (
  input  wire logic     CLOCK_50,
  input  wire logic     reset,
  car_lane_ctrl_if.slave bus
);

  localparam int                LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [LANE_W-1:0] START_LANE = LANE_W'(NUM_LANES / 2);
  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(NUM_LANES - 1);
  localparam logic [XW-1:0]     START_X    = XW'(lane_x_px(LANE0_X, LANE_WIDTH, NUM_LANES / 2));
  localparam logic [XW-1:0]     STEP_X     = XW'(STEP_PX);
  localparam logic [XW:0]       STEP_WIDE  = (XW+1)'(STEP_PX);

  game_state_t        r_state;
  logic [LANE_W-1:0]  r_lane;
  logic [LANE_W-1:0]  r_target;
  logic [XW-1:0]      r_car_x;
  logic [SCORE_W-1:0] r_score;
  logic               r_pend_valid;
  logic               r_pend_right;

  logic [2:0]         w_press;
  logic               w_enter_p;
  logic               w_left_p;
  logic               w_right_p;
  logic               w_have_fresh;
  logic               w_req_left;
  logic               w_req_right;
  logic               w_active;
  logic [XW-1:0]      w_target_x;
  logic signed [XW:0] w_rem;
  logic [XW:0]        w_abs;
  logic               w_snap;

  key_edge_detect #(
    .WIDTH (3)
  ) u_key_edge (
    .clk   (CLOCK_50),
    .rst   (reset),
    .level ({bus.enter_en, bus.left_en, bus.right_en}),
    .pulse (w_press)
  );

  // Left and right arriving together cancel each other
  assign w_enter_p    = w_press[2];
  assign w_left_p     = w_press[1] & ~w_press[0];
  assign w_right_p    = w_press[0] & ~w_press[1];
  assign w_have_fresh = w_left_p | w_right_p;

  // A fresh press is newer than anything buffered, so it wins
  assign w_req_left  = w_have_fresh ? w_left_p  : (r_pend_valid & ~r_pend_right);
  assign w_req_right = w_have_fresh ? w_right_p : (r_pend_valid &  r_pend_right);

  assign w_active = (r_state == ST_PLAYING) || (r_state == ST_MOVING);

  // Distance still to travel; snap once within one step of the target lane
  assign w_target_x = XW'(lane_x_px(LANE0_X, LANE_WIDTH, int'(r_target)));
  assign w_rem      = $signed({1'b0, w_target_x}) - $signed({1'b0, r_car_x});
  assign w_abs      = w_rem[XW] ? $unsigned(-w_rem) : $unsigned(w_rem);
  assign w_snap     = (w_abs <= STEP_WIDE);

  // Game FSM with car position, lane, pending move and score
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_lane       <= START_LANE;
      r_target     <= START_LANE;
      r_car_x      <= START_X;
      r_score      <= '0;
      r_pend_valid <= 1'b0;
      r_pend_right <= 1'b0;
    end else begin
      if (w_active && bus.frame_tick && (r_score != '1)) begin
        r_score <= r_score + 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_enter_p) begin
            r_state <= ST_PLAYING;
            r_score <= '0;
          end
        end
        ST_PLAYING: begin
          r_pend_valid <= 1'b0;
          if (bus.collision) begin
            r_state <= ST_GAME_OVER;
          end else if (w_req_left && (r_lane != '0)) begin
            r_target <= r_lane - 1'b1;
            r_state  <= ST_MOVING;
          end else if (w_req_right && (r_lane != LAST_LANE)) begin
            r_target <= r_lane + 1'b1;
            r_state  <= ST_MOVING;
          end
        end
        ST_MOVING: begin
          if (bus.collision) begin
            r_state      <= ST_GAME_OVER;
            r_pend_valid <= 1'b0;
          end else begin
            if (w_have_fresh) begin
              r_pend_valid <= 1'b1;
              r_pend_right <= w_right_p;
            end
            if (bus.frame_tick) begin
              if (w_snap) begin
                r_car_x <= w_target_x;
                r_lane  <= r_target;
                r_state <= ST_PLAYING;
              end else if (w_rem[XW]) begin
                r_car_x <= r_car_x - STEP_X;
              end else begin
                r_car_x <= r_car_x + STEP_X;
              end
            end
          end
        end
        ST_GAME_OVER: begin
          if (w_enter_p) begin
            r_state  <= ST_IDLE;
            r_lane   <= START_LANE;
            r_target <= START_LANE;
            r_car_x  <= START_X;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.car_x       = r_car_x;
  assign bus.lane        = r_lane;
  assign bus.score       = r_score;
  assign bus.game_active = w_active;
  assign bus.game_over   = (r_state == ST_GAME_OVER);
  assign bus.moving      = (r_state == ST_MOVING);

endmodule
`default_nettype wire

// File: tb/tb_car_lane_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_car_lane_ctrl
//  Purpose  : Self-checking bench for car_lane_ctrl: vector table, directed
//             corner sequences and randomized run against a lane model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_car_lane_ctrl;

  localparam int N_LANES = 3;
  localparam int L0_X    = 20;
  localparam int L_PITCH = 40;
  localparam int STEP    = 4;
  localparam int SW      = 6;
  localparam int SMAX    = (1 << SW) - 1;
  localparam int START_L = N_LANES / 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  car_lane_ctrl_if #(.NUM_LANES(N_LANES), .XW(9), .SCORE_W(SW)) bus ();

  car_lane_ctrl #(
    .NUM_LANES (N_LANES), .LANE0_X (L0_X), .LANE_WIDTH (L_PITCH),
    .STEP_PX (STEP), .XW (9), .SCORE_W (SW)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit model_chk = 0;

  // Reference model: running/over flags, pixel position, lanes, buffered move
  bit m_running, m_over;
  int m_x, m_lane, m_target, m_pend, m_score;
  bit m_he, m_hl, m_hr, m_pe, m_pl, m_pr;

  function automatic int lx(input int n);
    return L0_X + n * L_PITCH;
  endfunction

  task automatic model_update();
    bit pe, pl, pr;
    int mv, req, d;
    if (reset) begin
      m_running = 0; m_over = 0; m_lane = START_L; m_target = START_L;
      m_x = lx(START_L); m_pend = 0; m_score = 0;
      {m_he, m_hl, m_hr, m_pe, m_pl, m_pr} = '0;
      return;
    end
    pe = m_pe; pl = m_pl; pr = m_pr;
    m_pe = bus.enter_en & ~m_he; m_he = bus.enter_en;
    m_pl = bus.left_en  & ~m_hl; m_hl = bus.left_en;
    m_pr = bus.right_en & ~m_hr; m_hr = bus.right_en;
    mv = (pl && !pr) ? -1 : ((pr && !pl) ? 1 : 0);
    if (m_running && bus.frame_tick && m_score < SMAX) m_score++;
    if (m_over) begin
      if (pe) begin
        m_over = 0; m_lane = START_L; m_target = START_L; m_x = lx(START_L);
      end
    end else if (!m_running) begin
      if (pe) begin m_running = 1; m_score = 0; end
    end else if (bus.collision) begin
      m_running = 0; m_over = 1; m_pend = 0; m_target = m_lane;
    end else if (m_target == m_lane) begin
      req = (mv != 0) ? mv : m_pend;
      m_pend = 0;
      if (req != 0 && m_lane + req >= 0 && m_lane + req < N_LANES) m_target = m_lane + req;
    end else begin
      if (mv != 0) m_pend = mv;
      if (bus.frame_tick) begin
        d = lx(m_target) - m_x;
        if (d <= STEP && d >= -STEP) begin
          m_x = lx(m_target); m_lane = m_target;
        end else begin
          m_x = m_x + ((d > 0) ? STEP : -STEP);
        end
      end
    end
  endtask

  task automatic check_out(input string name, input int ex, input int el, input int ea,
                           input int eo, input int em, input int es);
    n_total++;
    if (int'(bus.car_x) == ex && int'(bus.lane) == el && int'(bus.game_active) == ea &&
        int'(bus.game_over) == eo && int'(bus.moving) == em && int'(bus.score) == es) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got x=%0d lane=%0d act=%0d over=%0d mov=%0d score=%0d, want x=%0d lane=%0d act=%0d over=%0d mov=%0d score=%0d",
               name, bus.car_x, bus.lane, bus.game_active, bus.game_over, bus.moving, bus.score,
               ex, el, ea, eo, em, es);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    if (model_chk)
      check_out("random", m_x, m_lane, int'(m_running), int'(m_over),
                int'(m_running && m_target != m_lane), m_score);
  endtask

  task automatic clear_inputs();
    bus.enter_en = 0; bus.left_en = 0; bus.right_en = 0;
    bus.frame_tick = 0; bus.collision = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1; step(); step();
    reset = 0;
  endtask

  // key: 0 enter, 1 left, 2 right; one cycle high then one low
  task automatic press(input int key);
    if (key == 0) bus.enter_en = 1; else if (key == 1) bus.left_en = 1; else bus.right_en = 1;
    step();
    clear_inputs();
    step();
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1; step();
    end
    bus.frame_tick = 0;
  endtask

  typedef struct {
    int enter, left, right, tk, coll;
    int x, lane, act, over, mov, score;
  } vec_t;

  vec_t vecs[14];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // enter, left, right, tick, coll | x, lane, act, over, mov, score
    vecs[0]  = '{1,0,0,0,0,  60,1,0,0,0,0};
    vecs[1]  = '{1,0,0,0,0,  60,1,1,0,0,0};
    vecs[2]  = '{1,0,0,1,0,  60,1,1,0,0,1};
    vecs[3]  = '{0,1,0,0,0,  60,1,1,0,0,1};
    vecs[4]  = '{0,1,0,0,0,  60,1,1,0,1,1};
    vecs[5]  = '{0,1,0,1,0,  56,1,1,0,1,2};
    vecs[6]  = '{0,0,1,0,0,  56,1,1,0,1,2};
    vecs[7]  = '{0,0,1,0,0,  56,1,1,0,1,2};
    vecs[8]  = '{0,0,0,1,0,  52,1,1,0,1,3};
    vecs[9]  = '{0,0,0,0,1,  52,1,0,1,0,3};
    vecs[10] = '{0,0,0,1,1,  52,1,0,1,0,3};
    vecs[11] = '{1,0,0,0,0,  52,1,0,1,0,3};
    vecs[12] = '{1,0,0,0,0,  60,1,0,0,0,3};
    vecs[13] = '{0,0,0,0,0,  60,1,0,0,0,3};

    do_reset();
    check_out("reset_state", 60, 1, 0, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      bus.enter_en = vecs[i].enter[0]; bus.left_en = vecs[i].left[0];
      bus.right_en = vecs[i].right[0]; bus.frame_tick = vecs[i].tk[0];
      bus.collision = vecs[i].coll[0];
      step();
      check_out($sformatf("vec%0d", i), vecs[i].x, vecs[i].lane, vecs[i].act,
                vecs[i].over, vecs[i].mov, vecs[i].score);
    end

    // Enter held for 100 cycles starts exactly one game
    do_reset();
    bus.enter_en = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (i == 1) check_val("enter_active_after_2", int'(bus.game_active), 1);
    end
    check_out("enter_held_100", 60, 1, 1, 0, 0, 0);
    clear_inputs(); step();

    // Left move animates to lane 0, then edge-lane press is ignored
    press(1);
    check_out("left_start", 60, 1, 1, 0, 1, 0);
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      check_val($sformatf("left_x_tick%0d", k), int'(bus.car_x), 60 - 4 * k);
    end
    check_out("left_arrived", 20, 0, 1, 0, 0, 10);
    press(1); step();
    check_out("left_edge_ignored", 20, 0, 1, 0, 0, 10);

    // Right move with a buffered left press returns to lane 1
    do_reset(); press(0);
    press(2); tick(3);
    check_val("pend_x72", int'(bus.car_x), 72);
    press(1);
    tick(7);
    check_out("pend_arrive_100", 100, 2, 1, 0, 0, 10);
    step();
    check_out("pend_applied", 100, 2, 1, 0, 1, 10);
    tick(10);
    check_out("pend_back_60", 60, 1, 1, 0, 0, 20);

    // Simultaneous left and right are both dropped
    do_reset(); press(0);
    bus.left_en = 1; bus.right_en = 1; step();
    clear_inputs(); step(); step();
    tick(2);
    check_out("both_dropped", 60, 1, 1, 0, 0, 2);

    // Collision mid-move freezes car and score; Enter returns to idle
    do_reset(); press(0);
    press(2); tick(3);
    bus.collision = 1; step(); bus.collision = 0;
    check_out("collide_over", 72, 1, 0, 1, 0, 3);
    tick(2);
    check_out("collide_frozen", 72, 1, 0, 1, 0, 3);
    press(0);
    check_out("over_to_idle", 60, 1, 0, 0, 0, 3);

    // Score saturation and reset in the middle of a move
    do_reset(); press(0);
    tick(SMAX - 1);
    check_val("score_max_m1", int'(bus.score), SMAX - 1);
    tick(1);
    check_val("score_max", int'(bus.score), SMAX);
    tick(2);
    check_val("score_saturated", int'(bus.score), SMAX);
    press(2); tick(2);
    check_out("pre_reset_move", 68, 1, 1, 0, 1, SMAX);
    reset = 1; step(); reset = 0;
    check_out("reset_mid_move", 60, 1, 0, 0, 0, 0);

    // Randomized run against the model
    do_reset();
    model_chk = 1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) bus.enter_en = ~bus.enter_en;
      if ($urandom_range(0, 5) == 0) bus.left_en = ~bus.left_en;
      if ($urandom_range(0, 5) == 0) bus.right_en = ~bus.right_en;
      bus.frame_tick = ($urandom_range(0, 3) == 0);
      bus.collision = ($urandom_range(0, 149) == 0);
      reset = ($urandom_range(0, 1999) == 0);
      step();
    end
    model_chk = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
